// File: rtl/rsa_pkg.sv
// Shared types for the RSA modular exponentiation datapath.
package rsa_pkg;

  // Exponentiation controller states.
  typedef enum logic [2:0] {
    IDLE,
    TO_MONT_M,
    TO_MONT_X,
    SQUARE,
    MULTIPLY,
    FROM_MONT,
    DONE
  } state_t;

  // Montgomery multiplier sequencing states.
  typedef enum logic [1:0] {
    MP_IDLE,
    MP_RUN,
    MP_FIN
  } mp_state_t;

endpackage

// File: rtl/monpro.sv
// Bit-serial radix-2 Montgomery product: o_U = i_A * i_B * 2^-DATAWIDTH mod i_N.
// One operand bit per cycle, then one cycle for the final conditional subtract.
module monpro
  import rsa_pkg::*;
#(
  parameter int DATAWIDTH = 256
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  output logic                 ready,
  output logic                 o_valid,
  input  logic [DATAWIDTH-1:0] i_A,
  input  logic [DATAWIDTH-1:0] i_B,
  input  logic [DATAWIDTH-1:0] i_N,
  output logic [DATAWIDTH-1:0] o_U
);

  localparam int CW = $clog2(DATAWIDTH);

  mp_state_t            state;
  logic [DATAWIDTH-1:0] a_r;
  logic [DATAWIDTH-1:0] b_r;
  logic [DATAWIDTH-1:0] n_r;
  // Two guard bits: the partial sum u + b + n stays below 4N.
  logic [DATAWIDTH+1:0] u_r;
  logic [CW-1:0]        cnt;

  logic [DATAWIDTH+1:0] u_add;
  logic [DATAWIDTH+1:0] u_red;
  logic [DATAWIDTH+1:0] u_fin;

  assign ready = (state == MP_IDLE);

  // One Montgomery step: add B if the current A bit is set, add N if odd, halve.
  // NOTE: every variable driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    u_add = u_r + (a_r[0] ? {2'b00, b_r} : '0);
    u_red = u_add[0] ? (u_add + {2'b00, n_r}) : u_add;
    u_fin = (u_r >= {2'b00, n_r}) ? (u_r - {2'b00, n_r}) : u_r;
  end

  // Sequencer: latch operands on start, iterate DATAWIDTH bits, emit a one-cycle o_valid.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= MP_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      n_r     <= '0;
      u_r     <= '0;
      cnt     <= '0;
      o_U     <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        MP_IDLE: begin
          if (start) begin
            a_r   <= i_A;
            b_r   <= i_B;
            n_r   <= i_N;
            u_r   <= '0;
            cnt   <= CW'(DATAWIDTH - 1);
            state <= MP_RUN;
          end
        end
        MP_RUN: begin
          u_r <= u_red >> 1;
          a_r <= a_r >> 1;
          if (cnt == '0) state <= MP_FIN;
          else           cnt   <= cnt - 1'b1;
        end
        MP_FIN: begin
          o_U     <= u_fin[DATAWIDTH-1:0];
          o_valid <= 1'b1;
          state   <= MP_IDLE;
        end
        default: state <= MP_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right binary modular exponentiation C = M^e mod N in the Montgomery
// domain, sequencing a single monpro instance.
module modexp_ctrl
  import rsa_pkg::*;
#(
  parameter int DATAWIDTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [DATAWIDTH-1:0] i_M,
  input  logic [DATAWIDTH-1:0] i_e,
  input  logic [DATAWIDTH-1:0] i_N,
  input  logic [DATAWIDTH-1:0] i_R2,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [DATAWIDTH-1:0] o_C
);

  localparam int                   IW      = $clog2(DATAWIDTH);
  localparam logic [IW-1:0]        IDX_TOP = IW'(DATAWIDTH - 1);
  localparam logic [DATAWIDTH-1:0] ONE     = {{(DATAWIDTH-1){1'b0}}, 1'b1};

  state_t               state;
  logic [DATAWIDTH-1:0] m_r;
  logic [DATAWIDTH-1:0] e_r;
  logic [DATAWIDTH-1:0] n_r;
  logic [DATAWIDTH-1:0] r2_r;
  logic [DATAWIDTH-1:0] m_bar;
  logic [DATAWIDTH-1:0] x_r;
  logic [IW-1:0]        idx;
  // Set once the current state's monpro call has been launched.
  logic                 issued;

  logic                 mp_start;
  logic                 mp_ready;
  logic                 mp_valid;
  logic [DATAWIDTH-1:0] mp_a;
  logic [DATAWIDTH-1:0] mp_b;
  logic [DATAWIDTH-1:0] mp_u;

  // Operand selection for the monpro call belonging to each state.
  always_comb begin
    mp_a = '0;
    mp_b = '0;
    case (state)
      TO_MONT_M: begin mp_a = m_r;   mp_b = r2_r; end
      TO_MONT_X: begin mp_a = ONE;   mp_b = r2_r; end
      SQUARE:    begin mp_a = x_r;   mp_b = x_r;  end
      MULTIPLY:  begin mp_a = m_bar; mp_b = x_r;  end
      FROM_MONT: begin mp_a = x_r;   mp_b = ONE;  end
      default:   begin mp_a = '0;    mp_b = '0;   end
    endcase
  end

  // Main FSM: operand handshake, one monpro call per compute state, result handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      o_ready  <= 1'b1;
      o_valid  <= 1'b0;
      o_C      <= '0;
      idx      <= '0;
      m_r      <= '0;
      e_r      <= '0;
      n_r      <= '0;
      r2_r     <= '0;
      m_bar    <= '0;
      x_r      <= '0;
      issued   <= 1'b0;
      mp_start <= 1'b0;
    end else begin
      mp_start <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid) begin
            m_r     <= i_M;
            e_r     <= i_e;
            n_r     <= i_N;
            r2_r    <= i_R2;
            issued  <= 1'b0;
            o_ready <= 1'b0;
            state   <= TO_MONT_M;
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          if (!issued) begin
            if (mp_ready) begin
              mp_start <= 1'b1;
              issued   <= 1'b1;
            end
          end else if (mp_valid) begin
            issued <= 1'b0;
            case (state)
              TO_MONT_M: begin
                m_bar <= mp_u;
                state <= TO_MONT_X;
              end
              TO_MONT_X: begin
                x_r   <= mp_u;
                idx   <= IDX_TOP;
                state <= SQUARE;
              end
              SQUARE: begin
                x_r <= mp_u;
                if (e_r[idx])        state <= MULTIPLY;
                else if (idx == '0)  state <= FROM_MONT;
                else                 idx   <= idx - 1'b1;
              end
              MULTIPLY: begin
                x_r <= mp_u;
                if (idx == '0) state <= FROM_MONT;
                else begin
                  idx   <= idx - 1'b1;
                  state <= SQUARE;
                end
              end
              FROM_MONT: begin
                o_C     <= mp_u;
                o_valid <= 1'b1;
                state   <= DONE;
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

  monpro #(
    .DATAWIDTH(DATAWIDTH)
  ) u_monpro (
    .clk     (clk),
    .rstn    (~rst),
    .start   (mp_start),
    .ready   (mp_ready),
    .o_valid (mp_valid),
    .i_A     (mp_a),
    .i_B     (mp_b),
    .i_N     (n_r),
    .o_U     (mp_u)
  );

endmodule

// File: tb/tb_modexp_ctrl.sv
// Testbench for modexp_ctrl at DATAWIDTH=8 with N=143, R2=42.
module tb_modexp_ctrl;
  import rsa_pkg::*;

  localparam int W  = 8;
  localparam int N  = 143;
  localparam int R2 = 42;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_M;
  logic [W-1:0] i_e;
  logic [W-1:0] i_N;
  logic [W-1:0] i_R2;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_C;

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;

  modexp_ctrl #(.DATAWIDTH(W)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_M     (i_M),
    .i_e     (i_e),
    .i_N     (i_N),
    .i_R2    (i_R2),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_C     (o_C)
  );

  always #5 clk = ~clk;

  // Count cycles in which a monpro call is launched.
  always @(negedge clk) if (u_dut.mp_start === 1'b1) start_cnt++;

  // Reference: M^e mod N by repeated modular multiplication.
  function automatic int ref_pow(input int m, input int e);
    longint r = 1;
    for (int k = 0; k < e; k++) r = (r * m) % N;
    return int'(r);
  endfunction

  function automatic int popcnt(input int v);
    int c = 0;
    for (int k = 0; k < W; k++) c += (v >> k) & 1;
    return c;
  endfunction

  // Launch one operation and wait for o_valid; leaves the result un-accepted.
  task automatic do_op(input logic [W-1:0] m, input logic [W-1:0] e,
                       output logic [W-1:0] c, output int starts, output bit ok);
    int s0;
    int n;
    ok = 1'b0; c = '0; starts = 0;
    n = 0;
    while (o_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    s0 = start_cnt;
    i_M = m; i_e = e; i_N = W'(N); i_R2 = W'(R2); i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    i_M = W'($urandom); i_e = W'($urandom); i_N = W'($urandom); i_R2 = W'($urandom);
    total++;
    if (o_ready !== 1'b0) begin
      bad++; $display("FAIL accept m=%0d e=%0d: o_ready=%b want 0", m, e, o_ready);
    end
    n = 0;
    while (o_valid !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
    if (o_valid !== 1'b1) begin
      total++; bad++;
      $display("FAIL timeout m=%0d e=%0d: o_valid=%b want 1", m, e, o_valid);
      return;
    end
    total++;
    if (o_ready !== 1'b0) begin
      bad++; $display("FAIL excl m=%0d e=%0d: o_ready=%b want 0 with o_valid", m, e, o_ready);
    end
    c = o_C; starts = start_cnt - s0; ok = 1'b1;
  endtask

  task automatic accept();
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
  endtask

  task automatic check_op(input string name, input int m, input int e);
    logic [W-1:0] c;
    int           starts;
    bit           ok;
    do_op(W'(m), W'(e), c, starts, ok);
    if (ok) begin
      total++;
      if (c !== W'(ref_pow(m, e))) begin
        bad++; $display("FAIL %s m=%0d e=%0d: o_C=%0d want %0d", name, m, e, c, ref_pow(m, e));
      end
      total++;
      if (starts != 3 + W + popcnt(e)) begin
        bad++; $display("FAIL %s_calls m=%0d e=%0d: starts=%0d want %0d", name, m, e, starts, 3 + W + popcnt(e));
      end
    end
    accept();
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    i_M = '0; i_e = '0; i_N = '0; i_R2 = '0;
    repeat (3) @(negedge clk);
    total++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_C !== '0) begin
      bad++; $display("FAIL reset: ready=%b valid=%b C=%0d want 1 0 0", o_ready, o_valid, o_C);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (o_ready !== 1'b1) begin
      bad++; $display("FAIL reset_idle: o_ready=%b want 1", o_ready);
    end
  endtask

  task automatic test_vectors();
    check_op("m2e7", 2, 7);
    check_op("e0", 5, 0);
    check_op("e1", 5, 1);
    check_op("m142e2", 142, 2);
    check_op("m0e5", 0, 5);
    check_op("e255", 3, 255);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      check_op("rand", int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)));
    end
  endtask

  // Hold i_ready low in DONE, then hand a new operand set straight back.
  task automatic test_hold_back_to_back();
    logic [W-1:0] c;
    int           starts;
    bit           ok;
    do_op(8'd2, 8'd7, c, starts, ok);
    if (ok) begin
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        total++;
        if (o_valid !== 1'b1 || o_C !== 8'd128) begin
          bad++; $display("FAIL hold cyc=%0d: valid=%b C=%0d want 1 128", k, o_valid, o_C);
        end
      end
    end
    accept();
    total++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_idle: ready=%b valid=%b want 1 0", o_ready, o_valid);
    end
    check_op("b2b", 7, 3);
  endtask

  task automatic test_mid_reset();
    int n;
    n = 0;
    while (o_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    i_M = 8'd2; i_e = 8'd7; i_N = W'(N); i_R2 = W'(R2); i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    n = 0;
    while (u_dut.state != SQUARE && n < 2000) begin @(negedge clk); n++; end
    total++;
    if (u_dut.state != SQUARE) begin
      bad++; $display("FAIL reach_square: state=%0d want %0d", u_dut.state, SQUARE);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      bad++; $display("FAIL mid_reset: valid=%b ready=%b want 0 1", o_valid, o_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    check_op("after_rst", 2, 7);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_hold_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/modexp_ctrl.md
MODEXP_CTRL -- requirements
Module: modexp_ctrl

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 256, operand/modulus width in bits, shared with monpro.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_valid  input  1  operand set valid.
REQ-005 SHALL have port o_ready  output  1  block idle, accepts operands.
REQ-006 SHALL have port i_M  input  DATAWIDTH  message, required M < N.
REQ-007 SHALL have port i_e  input  DATAWIDTH  exponent.
REQ-008 SHALL have port i_N  input  DATAWIDTH  modulus, required odd and > 1.
REQ-009 SHALL have port i_R2  input  DATAWIDTH  R^2 mod N, R = 2^DATAWIDTH.
REQ-010 SHALL have port o_valid  output  1  result valid, held until accepted.
REQ-011 SHALL have port i_ready  input  1  downstream accepts result.
REQ-012 SHALL have port o_C  output  DATAWIDTH  result M^e mod N.

Function
REQ-013 SHALL accept operands when i_valid & o_ready, registering i_M, i_e, i_N, i_R2 in that cycle; later input changes ignored.
REQ-014 SHALL compute left-to-right binary Montgomery exponentiation using exactly one monpro instance.
REQ-015 SHALL use FSM states IDLE, TO_MONT_M, TO_MONT_X, SQUARE, MULTIPLY, FROM_MONT, DONE.
REQ-016 SHALL, in TO_MONT_M, compute M_bar = monpro(M, R2); in TO_MONT_X, X = monpro(1, R2).
REQ-017 SHALL initialise bit index to DATAWIDTH-1 on leaving TO_MONT_X and scan all DATAWIDTH bits, no leading-zero skip.
REQ-018 SHALL, in SQUARE, compute X = monpro(X, X); then go to MULTIPLY if e[index]=1, else decrement index.
REQ-019 SHALL, in MULTIPLY, compute X = monpro(M_bar, X), then decrement index.
REQ-020 SHALL go to FROM_MONT after bit 0 is processed; no index wrap-around; FROM_MONT computes C = monpro(X, 1).
REQ-021 SHALL, per monpro call, assert monpro start for exactly one cycle only while monpro ready=1, then wait for monpro o_valid and capture o_U that cycle.
REQ-022 SHALL issue exactly 3 + DATAWIDTH + popcount(e) monpro calls per operation.
REQ-023 SHALL, in DONE, drive o_C and hold o_valid=1 with o_C stable until i_ready=1; same cycle return to IDLE.
REQ-024 SHALL keep o_ready=1 only in IDLE; o_valid=1 only in DONE; o_ready and o_valid never both 1.
REQ-025 SHALL produce 1 for e=0, M for e=1, and 0 for M=0 with e>0.
REQ-026 SHALL accept a new operand set the cycle after DONE handshake (back-to-back, no bubble beyond IDLE cycle).
REQ-027 SHALL leave results for M>=N, even N or N<=1 undefined, no hang required-free guarantee beyond REQ-022 call count.

Reset
REQ-028 SHALL on rst force state IDLE, o_ready=1, o_valid=0, o_C=0, index=0, all operand/working registers 0.
REQ-029 SHALL drive monpro rstn = ~rst so a mid-operation reset aborts monpro and discards any in-flight result.
REQ-030 SHALL after reset release start a new operation with no residue from an aborted one.

Structure
REQ-031 SHALL place FSM state enum typedef in shared package rsa_pkg; DATAWIDTH stays a module parameter.
REQ-032 SHALL instantiate sub-module monpro (ports clk, rstn, start, ready, o_valid, i_A, i_B, i_N, o_U), sized DATAWIDTH.
REQ-033 SHALL size bit index to $clog2(DATAWIDTH) bits.

Verification (DATAWIDTH=8, N=143, R2=42)
REQ-034 SHALL verify M=2, e=7 -> o_C=128, 3+8+3=14 monpro starts counted.
REQ-035 SHALL verify M=5, e=0 -> o_C=1; M=5, e=1 -> o_C=5.
REQ-036 SHALL verify M=142, e=2 -> o_C=1; M=0, e=5 -> o_C=0.
REQ-037 SHALL verify i_ready held 0 for 10 cycles in DONE -> o_valid and o_C=128 stable, then accepted; next operand set accepted back-to-back.
REQ-038 SHALL verify rst pulsed during SQUARE -> o_valid=0, o_ready=1 next cycle; subsequent M=2, e=7 -> 128.
